mem_burst_ctrl: RTL



---
 rtl/mem_burst_pkg.sv | 22 ++
 rtl/mem_burst_if.sv | 63 ++++++
 rtl/mem_burst_addr_gen.sv | 50 +++++
 rtl/mem_burst_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared widths, FSM state encoding and op codes for the memory burst sequencer.
package mem_burst_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Same encoding as the memory rw pin
  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_burst_if.sv
// Client command/data handshakes plus memory-side pins of the burst sequencer.
// MEM_BURST_STATS_EN adds the beat counters to the bundle.
interface mem_burst_if
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = mem_burst_pkg::ADDR_W,
  parameter int DATA_W = mem_burst_pkg::DATA_W,
  parameter int LEN_W  = mem_burst_pkg::LEN_W
);

  // Every channel transfers on a clk edge where valid & ready are both high.
  // valid must not depend on ready; ready may depend on valid.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_valid;
`ifdef MEM_BURST_STATS_EN
  logic [15:0]       wr_beat_cnt;
  logic [15:0]       rd_beat_cnt;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_data_out, mem_data_valid,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, mem_rw, mem_addr,
           mem_data_in, wr_beat_cnt, rd_beat_cnt
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_data_out, mem_data_valid,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, mem_rw, mem_addr,
           mem_data_in, wr_beat_cnt, rd_beat_cnt
  );
`else
  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_data_out, mem_data_valid,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, mem_rw, mem_addr,
           mem_data_in
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_data_out, mem_data_valid,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, mem_rw, mem_addr,
           mem_data_in
  );
`endif

endinterface

// File: rtl/mem_burst_addr_gen.sv
// Burst address walker: loads start/length, steps with wrap at 2^ADDR_W,
// flags the final beat.
module mem_burst_addr_gen
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = mem_burst_pkg::ADDR_W,
  parameter int LEN_W  = mem_burst_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      cur_addr_d  = start_i;
      remaining_d = len_i;
    end else if (step_i) begin
      cur_addr_d = cur_addr_q + ADDR_W'(1);
      // Parks at zero after the last beat instead of wrapping round
      if (remaining_q != '0) begin
        remaining_d = remaining_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign last_o     = (remaining_q == '0);

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of the 16x8 memory: one command per burst, streams
// write beats in or read beats out. MEM_BURST_STATS_EN adds beat counters.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = mem_burst_pkg::ADDR_W,
  parameter int DATA_W = mem_burst_pkg::DATA_W,
  parameter int LEN_W  = mem_burst_pkg::LEN_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_burst_if.slave  bus,
  output state_e      dbg_state_o
);

  state_e            state_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_cap;

  assign cmd_fire = (state_q == IDLE) & ~rd_valid_q & bus.cmd_valid;
  assign wr_fire  = (state_q == WRITE) & bus.wr_valid;
  // Capture only when the output slot is empty or being drained this cycle
  assign rd_cap   = (state_q == READ) & (~rd_valid_q | bus.rd_ready)
                  & bus.mem_data_valid;

  mem_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cmd_fire),
    .start_i    (bus.cmd_addr),
    .len_i      (bus.cmd_len),
    .step_i     (wr_fire | rd_cap),
    .cur_addr_o (cur_addr),
    .last_o     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            state_q <= (bus.cmd_rw == OP_WRITE) ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire && last) begin
            state_q <= IDLE;
          end
        end
        READ: begin
          if (rd_cap && last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rd_cap) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.mem_data_out;
      end else if (bus.rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE) & ~rd_valid_q;
  assign bus.wr_ready    = (state_q == WRITE);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = (state_q != IDLE) | rd_valid_q;
  // The memory commits on the same edge as the write handshake
  assign bus.mem_rw      = wr_fire ? OP_WRITE : OP_READ;
  assign bus.mem_addr    = cur_addr;
  assign bus.mem_data_in = (state_q == WRITE) ? bus.wr_data : '0;
  assign dbg_state_o     = state_q;

`ifdef MEM_BURST_STATS_EN
  logic [15:0] wr_beat_cnt_q;
  logic [15:0] rd_beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_beat_cnt_q <= '0;
      rd_beat_cnt_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_beat_cnt_q <= sat_inc16(wr_beat_cnt_q);
      end
      if (rd_valid_q && bus.rd_ready) begin
        rd_beat_cnt_q <= sat_inc16(rd_beat_cnt_q);
      end
    end
  end

  assign bus.wr_beat_cnt = wr_beat_cnt_q;
  assign bus.rd_beat_cnt = rd_beat_cnt_q;
`endif

endmodule
